// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output-side blocks: data width and the
// frame tracker state encoding.
package fir_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [0:0] {
        StIdle,
        StInFrame
    } frame_state_e;

endpackage

// File: rtl/fir_sm_fifo_if.sv
// AXI-Stream style handshake bundle; master drives valid/data/last, slave drives ready.
interface fir_sm_fifo_if
    import fir_pkg::*;
#(
    parameter int unsigned DW = DataWidth
) ();

    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tready;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);

endinterface

// File: rtl/fir_sm_fifo_frame_stat.sv
// Output-side frame tracker: counts popped beats and sums their data per frame,
// publishing length/sum with a one-cycle done pulse when the tlast beat leaves.
module fir_sm_fifo_frame_stat
    import fir_pkg::*;
#(
    parameter int unsigned DataW = DataWidth
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pop_i,
    input  logic [DataW-1:0] tdata_i,
    input  logic             tlast_i,
    output logic             frame_active_o,
    output logic             frame_done_o,
    output logic [31:0]      frame_len_o,
    output logic [31:0]      frame_sum_o
);

    frame_state_e state_q, state_d;
    logic [31:0]  len_acc_q, len_acc_d;
    logic [31:0]  sum_acc_q, sum_acc_d;
    logic [31:0]  frame_len_q, frame_len_d;
    logic [31:0]  frame_sum_q, frame_sum_d;
    logic         frame_done_q, frame_done_d;
    logic [31:0]  len_inc;
    logic [31:0]  sum_inc;

    always_comb begin
        state_d      = state_q;
        len_acc_d    = len_acc_q;
        sum_acc_d    = sum_acc_q;
        frame_len_d  = frame_len_q;
        frame_sum_d  = frame_sum_q;
        frame_done_d = 1'b0;
        // Length saturates rather than wrapping; the sum wraps mod 2^32.
        len_inc      = (len_acc_q == '1) ? len_acc_q : len_acc_q + 32'd1;
        sum_inc      = sum_acc_q + 32'(tdata_i);
        if (pop_i) begin
            if (tlast_i) begin
                state_d      = StIdle;
                frame_len_d  = len_inc;
                frame_sum_d  = sum_inc;
                frame_done_d = 1'b1;
                len_acc_d    = '0;
                sum_acc_d    = '0;
            end else begin
                state_d   = StInFrame;
                len_acc_d = len_inc;
                sum_acc_d = sum_inc;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            len_acc_q    <= '0;
            sum_acc_q    <= '0;
            frame_len_q  <= '0;
            frame_sum_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_acc_q    <= len_acc_d;
            sum_acc_q    <= sum_acc_d;
            frame_len_q  <= frame_len_d;
            frame_sum_q  <= frame_sum_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign frame_active_o = (state_q == StInFrame);
    assign frame_done_o   = frame_done_q;
    assign frame_len_o    = frame_len_q;
    assign frame_sum_o    = frame_sum_q;

endmodule

// File: rtl/fir_sm_fifo.sv
// Register-based show-ahead FIFO between the FIR stream output and the DMA side,
// with per-frame length/sum statistics taken on the output side.
module fir_sm_fifo
    import fir_pkg::*;
#(
    parameter int unsigned pDATA_WIDTH = DataWidth,
    parameter int unsigned pDEPTH      = 8,
    parameter int unsigned pLVL_WIDTH  = $clog2(pDEPTH) + 1
) (
    input  logic                  axis_clk,
    input  logic                  axis_rst,
    fir_sm_fifo_if.slave          s_axis,
    fir_sm_fifo_if.master         m_axis,
    output logic [pLVL_WIDTH-1:0] level,
    output logic                  frame_active,
    output logic                  frame_done,
    output logic [31:0]           frame_len,
    output logic [31:0]           frame_sum
);

    localparam int unsigned AddrW = $clog2(pDEPTH);
    localparam int unsigned PtrW  = AddrW + 1;

    logic [pDATA_WIDTH:0] mem_q [pDEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic                 run_q;
    logic                 empty, full, push, pop;
    logic [pDATA_WIDTH:0] head;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
        // run_q keeps ready low until the first edge after reset release.
        s_axis.tready = run_q && !full;
        push          = s_axis.tvalid && run_q && !full;
        head          = mem_q[rd_ptr_q[AddrW-1:0]];
        m_axis.tvalid = !empty;
        m_axis.tdata  = empty ? '0 : head[pDATA_WIDTH-1:0];
        m_axis.tlast  = !empty && head[pDATA_WIDTH];
        pop           = !empty && m_axis.tready;
        wr_ptr_d      = wr_ptr_q + PtrW'(push);
        rd_ptr_d      = rd_ptr_q + PtrW'(pop);
        level         = pLVL_WIDTH'(wr_ptr_q - rd_ptr_q);
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            run_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            run_q    <= 1'b1;
        end
    end

    // Storage needs no reset: output data is masked to zero while empty.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    fir_sm_fifo_frame_stat #(
        .DataW (pDATA_WIDTH)
    ) u_frame_stat (
        .clk_i          (axis_clk),
        .rst_i          (axis_rst),
        .pop_i          (pop),
        .tdata_i        (m_axis.tdata),
        .tlast_i        (m_axis.tlast),
        .frame_active_o (frame_active),
        .frame_done_o   (frame_done),
        .frame_len_o    (frame_len),
        .frame_sum_o    (frame_sum)
    );

endmodule

// File: tb/tb_fir_sm_fifo.sv
// Scenario bench for fir_sm_fifo: accepted input beats feed a scoreboard queue,
// popped output beats are collected and compared in order by each scenario.
module tb_fir_sm_fifo;

    logic        clk;
    logic        rst;
    logic [3:0]  level;
    logic        frame_active;
    logic        frame_done;
    logic [31:0] frame_len;
    logic [31:0] frame_sum;

    int n_cmp;
    int n_bad;

    logic [32:0] exp_q[$];
    logic [32:0] got_q[$];

    fir_sm_fifo_if #(.DW(32)) s_if ();
    fir_sm_fifo_if #(.DW(32)) m_if ();

    fir_sm_fifo #(
        .pDATA_WIDTH (32),
        .pDEPTH      (8),
        .pLVL_WIDTH  (4)
    ) dut (
        .axis_clk     (clk),
        .axis_rst     (rst),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .level        (level),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .frame_sum    (frame_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard feeds: expected on accepted input, observed on accepted output.
    always @(posedge clk) begin
        if (!rst && s_if.tvalid && s_if.tready) exp_q.push_back({s_if.tlast, s_if.tdata});
        if (!rst && m_if.tvalid && m_if.tready) got_q.push_back({m_if.tlast, m_if.tdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold a beat on the input until it is accepted (bounded); ok=0 on timeout.
    task automatic send_beat(input logic [31:0] d, input logic l, output bit ok);
        bit was;
        ok = 1'b0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = l;
        for (int k = 0; k < 50; k++) begin
            was = s_if.tready;
            tick();
            if (was) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp += 9;
        if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL rst_s_tready got %b want 0", s_if.tready); end
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_m_tvalid got %b want 0", m_if.tvalid); end
        if (m_if.tdata !== 32'h0) begin n_bad++; $display("FAIL rst_m_tdata got %h want 0", m_if.tdata); end
        if (m_if.tlast !== 1'b0) begin n_bad++; $display("FAIL rst_m_tlast got %b want 0", m_if.tlast); end
        if (level !== 4'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level); end
        if (frame_active !== 1'b0) begin n_bad++; $display("FAIL rst_active got %b want 0", frame_active); end
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", frame_done); end
        if (frame_len !== 32'd0) begin n_bad++; $display("FAIL rst_len got %0d want 0", frame_len); end
        if (frame_sum !== 32'd0) begin n_bad++; $display("FAIL rst_sum got %h want 0", frame_sum); end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL rel_s_tready got %b want 0", s_if.tready); end
        tick();
        n_cmp++;
        if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL post_rst_s_tready got %b want 1", s_if.tready); end
    endtask

    task automatic test_single_beat();
        logic [32:0] g, e;
        m_if.tready = 1'b1;
        s_if.tvalid = 1'b1;
        s_if.tdata  = 32'h0000_0005;
        s_if.tlast  = 1'b1;
        n_cmp++;
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL sb_pre_valid got %b want 0", m_if.tvalid); end
        tick();
        s_if.tvalid = 1'b0;
        n_cmp += 3;
        if (m_if.tvalid !== 1'b1) begin n_bad++; $display("FAIL sb_valid got %b want 1", m_if.tvalid); end
        if (m_if.tdata !== 32'h5) begin n_bad++; $display("FAIL sb_data got %h want 5", m_if.tdata); end
        if (m_if.tlast !== 1'b1) begin n_bad++; $display("FAIL sb_last got %b want 1", m_if.tlast); end
        tick();
        n_cmp += 3;
        if (frame_done !== 1'b1) begin n_bad++; $display("FAIL sb_done got %b want 1", frame_done); end
        if (frame_len !== 32'd1) begin n_bad++; $display("FAIL sb_len got %0d want 1", frame_len); end
        if (frame_sum !== 32'd5) begin n_bad++; $display("FAIL sb_sum got %0d want 5", frame_sum); end
        tick();
        n_cmp++;
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL sb_done_pulse got %b want 0", frame_done); end
        n_cmp++;
        if (got_q.size() !== 1 || exp_q.size() !== 1) begin
            n_bad++;
            $display("FAIL sb_count got %0d want %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL sb_beat got %h want %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_fill_backpressure();
        logic [32:0] g, e;
        bit ok;
        m_if.tready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = 32'(i);
            s_if.tlast  = 1'b0;
            n_cmp++;
            if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL fill_ready[%0d] got 0 want 1", i); end
            tick();
        end
        s_if.tdata = 32'd9;
        n_cmp += 2;
        if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL fill_full_ready got 1 want 0"); end
        if (level !== 4'd8) begin n_bad++; $display("FAIL fill_level got %0d want 8", level); end
        m_if.tready = 1'b1;
        tick();
        n_cmp += 2;
        if (s_if.tready !== 1'b1) begin n_bad++; $display("FAIL fill_reready got 0 want 1"); end
        if (level !== 4'd7) begin n_bad++; $display("FAIL fill_level_pop got %0d want 7", level); end
        send_beat(32'd9, 1'b0, ok);
        send_beat(32'd10, 1'b1, ok);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 30 && m_if.tvalid; k++) tick();
        n_cmp++;
        if (got_q.size() !== 10 || exp_q.size() !== 10) begin
            n_bad++;
            $display("FAIL fill_count got %0d want %0d (of 10)", got_q.size(), exp_q.size());
        end
        for (int i = 1; got_q.size() > 0 && exp_q.size() > 0; i++) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e || g[31:0] !== 32'(i)) begin
                n_bad++;
                $display("FAIL fill_order got %h want %h", g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_full_pop();
        logic [32:0] g, e;
        bit ok;
        m_if.tready = 1'b0;
        for (int i = 0; i < 8; i++) send_beat(32'h100 + 32'(i), 1'b0, ok);
        s_if.tdata  = 32'h200;
        s_if.tlast  = 1'b1;
        m_if.tready = 1'b1;
        n_cmp += 2;
        if (level !== 4'd8) begin n_bad++; $display("FAIL full_level got %0d want 8", level); end
        if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL full_ready got 1 want 0"); end
        tick();
        n_cmp++;
        if (level !== 4'd7) begin n_bad++; $display("FAIL full_pop_level got %0d want 7", level); end
        tick();
        s_if.tvalid = 1'b0;
        n_cmp++;
        if (level !== 4'd7) begin n_bad++; $display("FAIL full_both_level got %0d want 7", level); end
        for (int k = 0; k < 30 && m_if.tvalid; k++) tick();
        n_cmp++;
        if (got_q.size() !== 9 || exp_q.size() !== 9) begin
            n_bad++;
            $display("FAIL full_count got %0d want %0d (of 9)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL full_beat got %h want %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_frame_600();
        logic [31:0] d [600];
        logic [31:0] model_sum;
        logic [32:0] g, e;
        int idx, pops, act_err, mis;
        bit last_seen, will_push, will_pop, pop_last, exp_act;
        model_sum = '0;
        for (int i = 0; i < 600; i++) begin
            d[i] = $urandom;
            model_sum += d[i];
        end
        idx = 0; pops = 0; act_err = 0; last_seen = 1'b0;
        for (int cyc = 0; cyc < 5000 && !last_seen; cyc++) begin
            m_if.tready = 1'($urandom_range(0, 1));
            if (idx < 600) begin
                s_if.tvalid = 1'b1;
                s_if.tdata  = d[idx];
                s_if.tlast  = (idx == 599);
            end else begin
                s_if.tvalid = 1'b0;
            end
            will_push = s_if.tvalid && s_if.tready;
            will_pop  = m_if.tvalid && m_if.tready;
            pop_last  = m_if.tlast;
            tick();
            if (will_push) idx++;
            if (will_pop) begin
                pops++;
                if (pop_last) last_seen = 1'b1;
            end
            exp_act = (pops > 0) && !last_seen;
            if (frame_active !== exp_act) act_err++;
        end
        s_if.tvalid = 1'b0;
        n_cmp += 6;
        if (!last_seen) begin n_bad++; $display("FAIL f600_timeout got pops=%0d want 600", pops); end
        if (frame_done !== 1'b1) begin n_bad++; $display("FAIL f600_done got %b want 1", frame_done); end
        if (frame_len !== 32'd600) begin n_bad++; $display("FAIL f600_len got %0d want 600", frame_len); end
        if (frame_sum !== model_sum) begin
            n_bad++;
            $display("FAIL f600_sum got %h want %h", frame_sum, model_sum);
        end
        if (act_err !== 0) begin n_bad++; $display("FAIL f600_active got %0d bad cycles want 0", act_err); end
        if (got_q.size() !== 600 || exp_q.size() !== 600) begin
            n_bad++;
            $display("FAIL f600_count got %0d want %0d (of 600)", got_q.size(), exp_q.size());
        end
        mis = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (g !== e) mis++;
        end
        n_cmp++;
        if (mis !== 0) begin n_bad++; $display("FAIL f600_beats got %0d wrong want 0", mis); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_wrap_sum();
        logic [32:0] g, e;
        bit ok;
        m_if.tready = 1'b1;
        send_beat(32'hFFFF_FFFF, 1'b0, ok);
        send_beat(32'h0000_0002, 1'b1, ok);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 20 && !frame_done; k++) tick();
        n_cmp += 3;
        if (frame_done !== 1'b1) begin n_bad++; $display("FAIL wrap_done got %b want 1", frame_done); end
        if (frame_len !== 32'd2) begin n_bad++; $display("FAIL wrap_len got %0d want 2", frame_len); end
        if (frame_sum !== 32'd1) begin n_bad++; $display("FAIL wrap_sum got %h want 1", frame_sum); end
        tick();
        tick();
        tick();
        n_cmp += 3;
        if (frame_done !== 1'b0) begin n_bad++; $display("FAIL wrap_done_clr got %b want 0", frame_done); end
        if (frame_len !== 32'd2) begin n_bad++; $display("FAIL wrap_len_hold got %0d want 2", frame_len); end
        if (frame_sum !== 32'd1) begin n_bad++; $display("FAIL wrap_sum_hold got %h want 1", frame_sum); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL wrap_beat got %h want %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [32:0] g, e;
        bit ok;
        m_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) send_beat(32'h30 + 32'(i), 1'b0, ok);
        s_if.tvalid = 1'b0;
        m_if.tready = 1'b1;
        tick();
        m_if.tready = 1'b0;
        n_cmp += 2;
        if (level !== 4'd5) begin n_bad++; $display("FAIL mid_level got %0d want 5", level); end
        if (frame_active !== 1'b1) begin n_bad++; $display("FAIL mid_active got %b want 1", frame_active); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp += 7;
        if (level !== 4'd0) begin n_bad++; $display("FAIL mid_rst_level got %0d want 0", level); end
        if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid got 1 want 0"); end
        if (m_if.tdata !== 32'h0) begin n_bad++; $display("FAIL mid_rst_data got %h want 0", m_if.tdata); end
        if (s_if.tready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready got 1 want 0"); end
        if (frame_active !== 1'b0) begin n_bad++; $display("FAIL mid_rst_active got 1 want 0"); end
        if (frame_len !== 32'd0) begin n_bad++; $display("FAIL mid_rst_len got %0d want 0", frame_len); end
        if (frame_sum !== 32'd0) begin n_bad++; $display("FAIL mid_rst_sum got %h want 0", frame_sum); end
        got_q.delete();
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        m_if.tready = 1'b1;
        send_beat(32'd7, 1'b0, ok);
        send_beat(32'd8, 1'b0, ok);
        send_beat(32'd9, 1'b1, ok);
        s_if.tvalid = 1'b0;
        for (int k = 0; k < 20 && !frame_done; k++) tick();
        n_cmp += 3;
        if (frame_done !== 1'b1) begin n_bad++; $display("FAIL new_done got %b want 1", frame_done); end
        if (frame_len !== 32'd3) begin n_bad++; $display("FAIL new_len got %0d want 3", frame_len); end
        if (frame_sum !== 32'd24) begin n_bad++; $display("FAIL new_sum got %0d want 24", frame_sum); end
        n_cmp++;
        if (got_q.size() !== 3 || exp_q.size() !== 3) begin
            n_bad++;
            $display("FAIL new_count got %0d want %0d (of 3)", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (g !== e) begin n_bad++; $display("FAIL new_beat got %h want %h", g, e); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;
        test_reset();
        test_single_beat();
        test_fill_backpressure();
        test_full_pop();
        test_frame_600();
        test_wrap_sum();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
